// File: rtl/voice_env_mixer.sv
// Multi-voice mixer: per-channel attack/release envelopes, sequential weighted sum,
// normalisation by active-voice count, and a glitch-free double-buffered PWM output.
module voice_env_mixer #(
    parameter int NUM_CH       = 12,
    parameter int SAMPLE_W     = 8,
    parameter int ENV_W        = 4,
    parameter int ATTACK_STEP  = 1,
    parameter int RELEASE_STEP = 1
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           sample_now,
    input  logic [NUM_CH*SAMPLE_W-1:0]     samples,
    input  logic [NUM_CH-1:0]              key_on,
    output logic [SAMPLE_W-1:0]            mix_out,
    output logic                           mix_valid,
    output logic [$clog2(NUM_CH+1)-1:0]    active_cnt,
    output logic                           overrun,
    output logic                           pwm_out
);

    localparam int CNT_W   = $clog2(NUM_CH + 1);
    localparam int ACC_W   = SAMPLE_W + CNT_W;
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PROD_W  = SAMPLE_W + ENV_W;
    localparam int ENV_MAX = (1 << ENV_W) - 1;

    typedef enum logic [1:0] {IDLE, ACCUM, NORM} state_t;

    function automatic logic [ENV_W-1:0] env_step(input logic [ENV_W-1:0] env,
                                                  input logic key);
        int e;
        e = int'(env);
        if (key) begin
            e = e + ATTACK_STEP;
            if (e > ENV_MAX) e = ENV_MAX;
        end else begin
            e = e - RELEASE_STEP;
            if (e < 0) e = 0;
        end
        return ENV_W'(e);
    endfunction

    // Divide by the next power of two >= n, then clamp to the sample range.
    function automatic logic [SAMPLE_W-1:0] norm_sat(input logic [ACC_W-1:0] acc,
                                                     input logic [CNT_W-1:0] n);
        logic [ACC_W-1:0] shifted;
        int s;
        if (n == '0) return '0;
        s = 0;
        for (int k = CNT_W; k >= 0; k--) begin
            if ((1 << k) >= int'(n)) s = k;
        end
        shifted = acc >> s;
        if (shifted > ACC_W'((1 << SAMPLE_W) - 1)) return '1;
        return shifted[SAMPLE_W-1:0];
    endfunction

    state_t                state_q, state_d;
    logic [ENV_W-1:0]      env_q  [NUM_CH];
    logic [ENV_W-1:0]      env_d  [NUM_CH];
    logic [SAMPLE_W-1:0]   snap_q [NUM_CH];
    logic [SAMPLE_W-1:0]   snap_d [NUM_CH];
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      n_q, n_d;
    logic [SAMPLE_W-1:0]   mix_q, mix_d;
    logic [CNT_W-1:0]      act_q, act_d;
    logic                  valid_q, valid_d;
    logic                  ovr_q, ovr_d;
    logic [SAMPLE_W-1:0]   cnt_q, cnt_d;
    logic [SAMPLE_W-1:0]   duty_q, duty_d;
    logic                  pwm_q, pwm_d;
    logic [PROD_W-1:0]     prod;

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        n_d     = n_q;
        mix_d   = mix_q;
        act_d   = act_q;
        valid_d = 1'b0;
        ovr_d   = 1'b0;
        prod    = '0;

        case (state_q)
            IDLE: begin
                if (sample_now) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        env_d[i]  = env_step(env_q[i], key_on[i]);
                        snap_d[i] = samples[i*SAMPLE_W +: SAMPLE_W];
                    end
                    idx_d   = '0;
                    acc_d   = '0;
                    n_d     = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                prod  = PROD_W'(snap_q[idx_q]) * PROD_W'(env_q[idx_q]);
                acc_d = acc_q + ACC_W'(prod >> ENV_W);
                if (env_q[idx_q] != '0) n_d = n_q + CNT_W'(1);
                if (idx_q == IDX_W'(NUM_CH - 1)) state_d = NORM;
                else idx_d = idx_q + IDX_W'(1);
            end
            NORM: begin
                mix_d   = norm_sat(acc_q, n_q);
                act_d   = n_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A strobe is only accepted in IDLE; anywhere else it is dropped and flagged.
        if (sample_now && (state_q != IDLE)) ovr_d = 1'b1;

        cnt_d  = cnt_q + SAMPLE_W'(1);
        duty_d = (cnt_q == '1) ? mix_q : duty_q;
        pwm_d  = (cnt_q < duty_q);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            env_q   <= '{default: '0};
            idx_q   <= '0;
            acc_q   <= '0;
            n_q     <= '0;
            mix_q   <= '0;
            act_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            mix_q   <= mix_d;
            act_q   <= act_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_d;
        end
    end

    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign mix_out    = mix_q;
    assign mix_valid  = valid_q;
    assign active_cnt = act_q;
    assign overrun    = ovr_q;
    assign pwm_out    = pwm_q;

endmodule
